// File: rtl/calendar_gen_if.sv
// Calendar generator bus: day-carry/adjust controls in, date fields and status out.
interface calendar_gen_if #(
    parameter int YEAR_W = 7
);
    logic              day_carry;
    logic [2:0]        set_sel;
    logic              inc;
    logic              dec;
    logic [YEAR_W-1:0] year;
    logic [3:0]        mon;
    logic [4:0]        day;
    logic [2:0]        wday;
    logic              year_carry;
    logic              pend_ovf;

    modport master (
        output day_carry, set_sel, inc, dec,
        input  year, mon, day, wday, year_carry, pend_ovf
    );

    modport slave (
        input  day_carry, set_sel, inc, dec,
        output year, mon, day, wday, year_carry, pend_ovf
    );
endinterface

// File: rtl/calendar_gen.sv
// Calendar generator: year/month/day/weekday with field adjust and queued day carries.
// Define CAL_LEAP_EN to give February 29 days in leap years; otherwise it is always 28.
module calendar_gen #(
    parameter int unsigned YEAR_BASE = 2000,
    parameter int          YEAR_W    = 7,
    parameter int unsigned YEAR_MAX  = 99,
    parameter int unsigned WDAY_INIT = 6,
    parameter int          PEND_W    = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    calendar_gen_if.slave bus
);
    localparam logic [YEAR_W-1:0] YMAX      = YEAR_MAX[YEAR_W-1:0];
    localparam logic [PEND_W-1:0] PEND_FULL = '1;

    logic [YEAR_W-1:0] year_q, year_adj, year_adv;
    logic [3:0]        mon_q, mon_adj, mon_adv;
    logic [4:0]        day_q, day_adj, day_adv;
    logic [2:0]        wday_q, wday_adj, wday_adv;
    logic [PEND_W-1:0] pend_q;
    logic              year_carry_q, pend_ovf_q;
    logic              wrap_adv, adj_mode, step_up, step_dn;
    logic [4:0]        feb_cur, feb_adj, len_cur, len_adj, day_step;

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic [4:0] feb);
        case (m)
            4'd2:                       return feb;
            4'd4, 4'd6, 4'd9, 4'd11:    return 5'd30;
            default:                    return 5'd31;
        endcase
    endfunction

`ifdef CAL_LEAP_EN
    function automatic logic [4:0] feb_len(input logic [YEAR_W-1:0] y);
        int unsigned a;
        a = YEAR_BASE + 32'(y);
        return ((a % 32'd4 == 32'd0) && ((a % 32'd100 != 32'd0) || (a % 32'd400 == 32'd0)))
               ? 5'd29 : 5'd28;
    endfunction

    assign feb_cur = feb_len(year_q);
    assign feb_adj = feb_len(year_adj);
`else
    assign feb_cur = 5'd28;
    assign feb_adj = 5'd28;
`endif

    assign adj_mode = (bus.set_sel >= 3'd1) && (bus.set_sel <= 3'd4);
    assign step_up  = bus.inc & ~bus.dec;
    assign step_dn  = bus.dec & ~bus.inc;
    assign len_cur  = month_len(mon_q, feb_cur);
    assign len_adj  = month_len(mon_adj, feb_adj);

    // One-day advance with ripple into month and year.
    always_comb begin
        wrap_adv = 1'b0;
        day_adv  = day_q + 5'd1;
        mon_adv  = mon_q;
        year_adv = year_q;
        wday_adv = (wday_q >= 3'd6) ? 3'd0 : wday_q + 3'd1;
        if (day_q >= len_cur) begin
            day_adv = 5'd1;
            if (mon_q >= 4'd12) begin
                mon_adv = 4'd1;
                if (year_q >= YMAX) begin
                    year_adv = '0;
                    wrap_adv = 1'b1;
                end else begin
                    year_adv = year_q + YEAR_W'(1);
                end
            end else begin
                mon_adv = mon_q + 4'd1;
            end
        end
    end

    always_comb begin
        year_adj = year_q;
        mon_adj  = mon_q;
        wday_adj = wday_q;
        day_step = day_q;
        if (step_up || step_dn) begin
            case (bus.set_sel)
                3'd1: year_adj = step_up ? ((year_q >= YMAX) ? '0 : year_q + YEAR_W'(1))
                                         : ((year_q == '0) ? YMAX : year_q - YEAR_W'(1));
                3'd2: mon_adj  = step_up ? ((mon_q >= 4'd12) ? 4'd1 : mon_q + 4'd1)
                                         : ((mon_q <= 4'd1) ? 4'd12 : mon_q - 4'd1);
                3'd3: day_step = step_up ? ((day_q >= len_cur) ? 5'd1 : day_q + 5'd1)
                                         : ((day_q <= 5'd1) ? len_cur : day_q - 5'd1);
                3'd4: wday_adj = step_up ? ((wday_q >= 3'd6) ? 3'd0 : wday_q + 3'd1)
                                         : ((wday_q == 3'd0) ? 3'd6 : wday_q - 3'd1);
                default: ;
            endcase
        end
    end

    // Year/month edits can shorten the month; the day follows in the same update.
    assign day_adj = (day_step > len_adj) ? len_adj : day_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            year_q       <= '0;
            mon_q        <= 4'd1;
            day_q        <= 5'd1;
            wday_q       <= WDAY_INIT[2:0];
            pend_q       <= '0;
            year_carry_q <= 1'b0;
            pend_ovf_q   <= 1'b0;
        end else begin
            year_carry_q <= 1'b0;
            if (!adj_mode) begin
                if (bus.day_carry || (pend_q != '0)) begin
                    year_q       <= year_adv;
                    mon_q        <= mon_adv;
                    day_q        <= day_adv;
                    wday_q       <= wday_adv;
                    year_carry_q <= wrap_adv;
                    if (!bus.day_carry) begin
                        pend_q <= pend_q - PEND_W'(1);
                    end
                end
            end else begin
                year_q <= year_adj;
                mon_q  <= mon_adj;
                day_q  <= day_adj;
                wday_q <= wday_adj;
                if (bus.day_carry) begin
                    if (pend_q == PEND_FULL) begin
                        pend_ovf_q <= 1'b1;
                    end else begin
                        pend_q <= pend_q + PEND_W'(1);
                    end
                end
            end
        end
    end

    assign bus.year       = year_q;
    assign bus.mon        = mon_q;
    assign bus.day        = day_q;
    assign bus.wday       = wday_q;
    assign bus.year_carry = year_carry_q;
    assign bus.pend_ovf   = pend_ovf_q;
endmodule

// File: tb/tb_calendar_gen.sv
// Self-checking bench for calendar_gen: calendar model compared every cycle plus literal date checks.
module tb_calendar_gen;
    localparam int YEAR_BASE = 2000;
    localparam int YEAR_W    = 7;
    localparam int YEAR_MAX  = 99;
    localparam int WDAY_INIT = 6;
    localparam int PEND_W    = 2;
    localparam int PEND_MAX  = (1 << PEND_W) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    calendar_gen_if #(.YEAR_W(YEAR_W)) bus ();

    calendar_gen #(
        .YEAR_BASE(YEAR_BASE), .YEAR_W(YEAR_W), .YEAR_MAX(YEAR_MAX),
        .WDAY_INIT(WDAY_INIT), .PEND_W(PEND_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int y; int m; int d; int w; int pend; int ovf; int yc;
    } cal_t;

    cal_t mdl;

    function automatic cal_t reset_state();
        cal_t s;
        s.y = 0; s.m = 1; s.d = 1; s.w = WDAY_INIT; s.pend = 0; s.ovf = 0; s.yc = 0;
        return s;
    endfunction

    function automatic int dim(int yoff, int m);
        int a;
        a = YEAR_BASE + yoff;
        if (m == 2) begin
`ifdef CAL_LEAP_EN
            if ((a % 4 == 0) && ((a % 100 != 0) || (a % 400 == 0))) return 29;
`endif
            return 28;
        end
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic cal_t advance(cal_t s);
        s.w = (s.w + 1) % 7;
        s.d = s.d + 1;
        if (s.d > dim(s.y, s.m)) begin s.d = 1; s.m = s.m + 1; end
        if (s.m > 12) begin s.m = 1; s.y = s.y + 1; end
        if (s.y > YEAR_MAX) begin s.y = 0; s.yc = 1; end
        return s;
    endfunction

    function automatic cal_t next_state(cal_t s, int sel, bit inc, bit dec, bit c);
        int dlt, len;
        s.yc = 0;
        if (sel < 1 || sel > 4) begin
            if (c) s = advance(s);
            else if (s.pend > 0) begin s = advance(s); s.pend = s.pend - 1; end
        end else begin
            if (inc != dec) begin
                dlt = inc ? 1 : -1;
                case (sel)
                    1: s.y = (s.y + dlt + YEAR_MAX + 1) % (YEAR_MAX + 1);
                    2: s.m = ((s.m - 1 + dlt + 12) % 12) + 1;
                    3: begin len = dim(s.y, s.m); s.d = ((s.d - 1 + dlt + len) % len) + 1; end
                    default: s.w = (s.w + dlt + 7) % 7;
                endcase
                if (s.d > dim(s.y, s.m)) s.d = dim(s.y, s.m);
            end
            if (c) begin
                if (s.pend == PEND_MAX) s.ovf = 1;
                else s.pend = s.pend + 1;
            end
        end
        return s;
    endfunction

    initial mdl = reset_state();

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) mdl <= reset_state();
        else mdl <= next_state(mdl, int'(bus.set_sel), bus.inc, bus.dec, bus.day_carry);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("year", int'(bus.year), mdl.y);
        check("mon", int'(bus.mon), mdl.m);
        check("day", int'(bus.day), mdl.d);
        check("wday", int'(bus.wday), mdl.w);
        check("year_carry", int'(bus.year_carry), mdl.yc);
        check("pend_ovf", int'(bus.pend_ovf), mdl.ovf);
    end

    task automatic lit_date(input string tag, input int y, input int m, input int d);
        check({tag, ".year"}, int'(bus.year), y);
        check({tag, ".mon"}, int'(bus.mon), m);
        check({tag, ".day"}, int'(bus.day), d);
    endtask

    task automatic step(input logic [2:0] sel, input logic i, input logic d, input logic c);
        bus.set_sel = sel; bus.inc = i; bus.dec = d; bus.day_carry = c;
        @(posedge clk); #1;
        bus.inc = 1'b0; bus.dec = 1'b0; bus.day_carry = 1'b0;
    endtask

    function automatic int field(int sel);
        case (sel)
            1: return mdl.y;
            2: return mdl.m;
            3: return mdl.d;
            default: return mdl.w;
        endcase
    endfunction

    task automatic adjust_to(input int sel, input int target);
        for (int n = 0; n < 200 && field(sel) != target; n++) step(3'(sel), 1'b1, 1'b0, 1'b0);
        check("adjust_to.reach", field(sel), target);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.set_sel = 3'd0; bus.inc = 1'b0; bus.dec = 1'b0; bus.day_carry = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        lit_date("reset", 0, 1, 1);
        check("reset.wday", int'(bus.wday), 6);
        check("reset.year_carry", int'(bus.year_carry), 0);
        check("reset.pend_ovf", int'(bus.pend_ovf), 0);

        // 2024-02-28 + 1 day
        adjust_to(1, 24); adjust_to(2, 2); adjust_to(3, 28);
        step(3'd0, 1'b0, 1'b0, 1'b1);
`ifdef CAL_LEAP_EN
        lit_date("leap2024", 24, 2, 29);
        step(3'd0, 1'b0, 1'b0, 1'b1);
`endif
        lit_date("leap2024.mar", 24, 3, 1);

        // 2000-02-28 + 1 day
        adjust_to(1, 0); adjust_to(2, 2); adjust_to(3, 28);
        step(3'd0, 1'b0, 1'b0, 1'b1);
`ifdef CAL_LEAP_EN
        lit_date("leap2000", 0, 2, 29);
`else
        lit_date("leap2000", 0, 3, 1);
`endif

        // 2099-12-31 wraps to 2000-01-01
        adjust_to(1, 99); adjust_to(2, 12); adjust_to(3, 31); adjust_to(4, 3);
        step(3'd0, 1'b0, 1'b0, 1'b1);
        lit_date("ywrap", 0, 1, 1);
        check("ywrap.wday", int'(bus.wday), 4);
        check("ywrap.year_carry", int'(bus.year_carry), 1);
        step(3'd0, 1'b0, 1'b0, 1'b0);
        check("ywrap.year_carry_drop", int'(bus.year_carry), 0);

        // Month edits clamp the day
        adjust_to(1, 23); adjust_to(2, 1); adjust_to(3, 31);
        step(3'd2, 1'b1, 1'b0, 1'b0);
        lit_date("clamp.inc", 23, 2, 28);
        step(3'd2, 1'b0, 1'b1, 1'b0);
        step(3'd2, 1'b0, 1'b1, 1'b0);
        lit_date("clamp.dec2", 23, 12, 28);
        step(3'd2, 1'b1, 1'b1, 1'b0);
        lit_date("clamp.both", 23, 12, 28);
        step(3'd5, 1'b1, 1'b0, 1'b0);
        lit_date("sel5.inc", 23, 12, 28);

        // Three queued carries drain on consecutive cycles
        adjust_to(2, 1); adjust_to(3, 30); adjust_to(4, 0);
        repeat (3) step(3'd3, 1'b0, 1'b0, 1'b1);
        lit_date("queue.hold", 23, 1, 30);
        step(3'd0, 1'b0, 1'b0, 1'b0);
        lit_date("queue.d1", 23, 1, 31);
        step(3'd0, 1'b0, 1'b0, 1'b0);
        lit_date("queue.d2", 23, 2, 1);
        step(3'd0, 1'b0, 1'b0, 1'b0);
        lit_date("queue.d3", 23, 2, 2);
        check("queue.wday", int'(bus.wday), 3);
        check("queue.pend_ovf", int'(bus.pend_ovf), 0);

        // Four carries with a three-deep queue: one is dropped
        repeat (4) step(3'd3, 1'b0, 1'b0, 1'b1);
        check("ovf.flag", int'(bus.pend_ovf), 1);
        repeat (4) step(3'd0, 1'b0, 1'b0, 1'b0);
        lit_date("ovf.drained", 23, 2, 5);
        check("ovf.wday", int'(bus.wday), 6);
        check("ovf.sticky", int'(bus.pend_ovf), 1);

        // Reset in the middle of a drain discards the queue
        repeat (3) step(3'd3, 1'b0, 1'b0, 1'b1);
        step(3'd0, 1'b0, 1'b0, 1'b0);
        lit_date("mid.d1", 23, 2, 6);
        #3 reset_n = 1'b0;
        #1;
        lit_date("mid.reset", 0, 1, 1);
        check("mid.reset.wday", int'(bus.wday), 6);
        check("mid.reset.pend_ovf", int'(bus.pend_ovf), 0);
        @(posedge clk); #3 reset_n = 1'b1;
        repeat (5) step(3'd0, 1'b0, 1'b0, 1'b0);
        lit_date("mid.after", 0, 1, 1);
        check("mid.after.wday", int'(bus.wday), 6);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calendar_gen.md
# calendar_gen

Parametrised calendar generator for the digital clock: keeps year, month, day and weekday. It advances on the day carry from the time-of-day block, and supports field-by-field adjustment with increment and decrement. Day carries that arrive while the user is adjusting are queued and applied afterwards instead of being lost. Sits between the time generator and the display multiplexer; the top-level mode decoder drives `set_sel`.

## Interface

Parameters:

- YEAR_BASE, 2000, absolute year represented by `year` = 0
- YEAR_W, 7, width of `year` offset
- YEAR_MAX, 99, last offset before wrap (must be < 2^YEAR_W)
- WDAY_INIT, 6, weekday at reset (0 = Sunday; 2000-01-01 is Saturday)
- PEND_W, 2, width of queued-carry counter

Ports:

- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous reset, active low
- day_carry  in  1  one-cycle pulse: one day elapsed
- set_sel  in  3  0 general, 1 year, 2 month, 3 day, 4 weekday, 5–7 treated as 0
- inc  in  1  one-cycle pulse: increment selected field
- dec  in  1  one-cycle pulse: decrement selected field
- year  out  YEAR_W  year offset from YEAR_BASE
- mon  out  4  month, 1..12
- day  out  5  day, 1..month length
- wday  out  3  weekday, 0..6
- year_carry  out  1  one-cycle pulse on wrap YEAR_MAX → 0
- pend_ovf  out  1  sticky: a queued carry was dropped

## Operation

- Reset values:
  - `year`=0, `mon`=1, `day`=1, `wday`=WDAY_INIT.
  - `year_carry`=0, `pend_ovf`=0.
  - Internal `pend`=0.
- Month length:
  - 30 for months 4, 6, 9, 11.
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - February 28, or 29 when leap (see Configuration).
  - Leap year uses absolute year A = YEAR_BASE + `year`: A%4==0 and (A%100!=0 or A%400==0).
- Advance (one day):
  - `day`+1; past month length, `day`→1 and `mon`+1.
  - Past 12, `mon`→1 and `year`+1.
  - Past YEAR_MAX, `year`→0 and `year_carry` pulses.
  - `wday`=(`wday`+1) mod 7 on every advance.
- Adjust mode (`set_sel` 1–4):
  - `inc` or `dec` changes only the selected field, wrapping within its range: year 0..YEAR_MAX, month 1..12, day 1..length, weekday 0..6.
  - No carry into other fields.
  - `inc` and `dec` asserted together: no change.
  - Year or month change whose result would exceed the new month length: `day` is clamped to that length in the same update.
- Carry queuing:
  - In adjust mode, `day_carry` increments `pend`, saturating at 2^PEND_W−1.
  - A carry arriving at saturation is dropped and sets `pend_ovf`.
  - In general mode, `day_carry` causes one advance; `pend` is unchanged that cycle.
  - In general mode with no `day_carry` and `pend`>0: one advance per cycle, `pend`−1.
  - `inc`/`dec` ignored in general mode.
- Adjust and queue interaction:
  - Adjust edits apply to the current stored date.
  - Queued advances apply on top after returning to general mode.

## Timing

- All outputs registered; an input sampled at edge N is reflected at edge N, visible in cycle N+1.
- `year_carry` is high exactly one cycle, coincident with `year`=0 appearing.
- Queue drain: `pend`=k with no further carries takes k consecutive cycles after `set_sel` returns to 0.
- Reset asserted mid-drain or mid-adjust: all state returns to reset values immediately (asynchronous); queued carries are discarded.
- Leaving adjust mode on the same edge as `day_carry`: that edge is treated as general mode.

## Configuration

- `CAL_LEAP_EN` defined:
  - February length is 29 in leap years per the rule above.
- `CAL_LEAP_EN` undefined:
  - February is always 28 days.
  - Leap logic is not synthesised.
  - Day 29 in February is unreachable by advance or adjust.
  - Clamping uses 28.

## Test plan

- Reset → `year`=0, `mon`=1, `day`=1, `wday`=6, `year_carry`=0, `pend_ovf`=0.
- Set `year`=24, 2/28; pulse `day_carry` → 2/29 with `CAL_LEAP_EN`, then → 3/1. Without the macro → 3/1 directly. Repeat with `year`=0: 2000 is leap.
- Set `year`=99, 12/31, `wday`=3; pulse `day_carry` → `year`=0, 1/1, `wday`=4; `year_carry` high for exactly one cycle.
- With `year`=23: `set_sel`=3, set `day`=31 in month 1; then `set_sel`=2, `inc` → `mon`=2, `day`=28. `dec` twice → `mon`=12, `day`=28. `inc`+`dec` together → unchanged.
- `set_sel`=3 at 1/30; 3 `day_carry` pulses; `set_sel`=0 → dates 1/31, 2/1, 2/2 on three consecutive cycles, `wday` +3, `pend_ovf`=0.
- With PEND_W=2, 4 pulses in adjust mode → only 3 advances applied and `pend_ovf`=1 until reset. Assert `reset_n` low mid-drain → reset values, no further advances.
